axis_data_to_axis_string: RTL and testbench
===========================================

Name: axis_data_to_axis_string

Overview:
Converts binary AXIS beats (tdata/tdest/tuser) into a byte-wide ASCII command string that axis_string_to_axis_data can parse. Each accepted input beat produces one line: DATA_PREFIX + hex data + DELIMITER + DEST_PREFIX + hex dest + DELIMITER + USER_PREFIX + hex user + TERMINATION. The block sits on the return path from the binary AXIS domain toward a UART or other ASCII console.

Parameters:
SBUS_WIDTH, 1, input data width in bytes.
USER_WIDTH, 4, tuser width in bits (≥1).
DEST_WIDTH, 4, tdest width in bits (≥1).
DELIMITER, ";", 8-bit field separator.
TERMINATION, "\n", 8-bit line terminator.
DATA_PREFIX, "#", 8-bit data field prefix.
DEST_PREFIX, "&", 8-bit dest field prefix.
USER_PREFIX, "*", 8-bit user field prefix.

Ports:
aclk  in  1  clock; all logic on rising edge.
arstn  in  1  reset; asynchronous, active-low.
s_axis_tdata  in  SBUS_WIDTH*8  binary data.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tuser  in  USER_WIDTH  user field.
s_axis_tdest  in  DEST_WIDTH  dest field.
m_axis_tdata  out  8  ASCII byte.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  high on the TERMINATION byte only.
m_axis_tready  in  1  output ready.

Behaviour:
- Reset (arstn=0, asynchronous): FSM=IDLE. s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0. Capture registers and digit counter are cleared.
- Digit counts:
  - ND = 2*SBUS_WIDTH.
  - NT = ceil(DEST_WIDTH/4).
  - NU = ceil(USER_WIDTH/4).
  - Fields are zero-extended at the MSB to a nibble multiple and emitted MSB nibble first.
- Nibble to ASCII: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase only).
- Line length: L = ND+NT+NU+6 bytes. L = 10 at default parameters.
- FSM states: IDLE, DPFX, DHEX, DLM1, TPFX, THEX, DLM2, UPFX, UHEX, TERM.
- IDLE:
  - s_axis_tready=1 (registered; first asserted the cycle after reset release).
  - On tvalid&&tready, latch data/dest/user and go to DPFX.
  - Next cycle: s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=DATA_PREFIX. Input-to-first-byte latency is 1 cycle.
- Output stepping:
  - Each state presents one byte and holds it stable while m_axis_tvalid&&!m_axis_tready.
  - The FSM advances only on m_axis_tvalid&&m_axis_tready.
  - Hex states loop on a digit counter from N-1 down to 0, then move to the next state.
- TERM:
  - Presents TERMINATION with m_axis_tlast=1.
  - On handshake: m_axis_tvalid=0, m_axis_tlast=0, FSM=IDLE, and s_axis_tready=1 the following cycle.
- Throughput: one input beat per L+1 cycles when m_axis_tready is held high. There are no gaps between bytes within a line.
- Input beats presented while s_axis_tready=0 are not consumed and must be held by the source (AXIS rule).
- m_axis_tvalid, once asserted, is never deasserted before its handshake.
- Reset asserted mid-line: the line is aborted immediately and no further bytes are emitted. After release, the block starts fresh in IDLE; there is no resumption.
- Captured values are used unmodified. Input changes after capture do not affect the line being emitted.

Test Plan:
- Basic conversion: data=0xA5, dest=0x3, user=0xC, m_axis_tready=1 → bytes "#A5;&3;*C\n" (0x23,0x41,0x35,0x3B,0x26,0x33,0x3B,0x2A,0x43,0x0A). tlast is set only on 0x0A. The first byte appears 1 cycle after the input handshake.
- Reset values and release: hold arstn=0 → all outputs 0. Release → s_axis_tready=1 next cycle, m_axis_tvalid=0.
- Backpressure: data=0x09, dest=0, user=0xF. Toggle m_axis_tready 1-0-0-1 per byte → bytes stay stable while stalled. Output is "#09;&0;*F\n" and no byte is duplicated or dropped.
- Back-to-back beats: two beats 0x00/0/0 and 0xFF/0xF/0xF with source tvalid held high → "#00;&0;*0\n#FF;&F;*F\n". The second input handshake occurs exactly 11 cycles after the first.
- Width config: SBUS_WIDTH=2, DEST_WIDTH=5, USER_WIDTH=1, data=0x1234, dest=0x11, user=1 → "#1234;&11;*1\n", 13 bytes.
- Mid-line reset: assert arstn after the 4th output byte → m_axis_tvalid=0 asynchronously. The next beat 0x5A/2/4 yields a clean "#5A;&2;*4\n".

Source files
------------

// File: rtl/axis_data_to_axis_string.sv
// Turns each binary AXIS beat (data/dest/user) into one ASCII line
// "<DP>hex<DL><TP>hex<DL><UP>hex<TERM>" on a byte-wide AXIS master.
module axis_data_to_axis_string #(
  parameter int          SBUS_WIDTH  = 1,
  parameter int          USER_WIDTH  = 4,
  parameter int          DEST_WIDTH  = 4,
  parameter logic [7:0]  DELIMITER   = 8'h3B,
  parameter logic [7:0]  TERMINATION = 8'h0A,
  parameter logic [7:0]  DATA_PREFIX = 8'h23,
  parameter logic [7:0]  DEST_PREFIX = 8'h26,
  parameter logic [7:0]  USER_PREFIX = 8'h2A
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [SBUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [3:0]              o_dbg_state
);

  localparam int ND   = 2 * SBUS_WIDTH;
  localparam int NT   = (DEST_WIDTH + 3) / 4;
  localparam int NU   = (USER_WIDTH + 3) / 4;
  localparam int DW   = ND * 4;
  localparam int TW   = NT * 4;
  localparam int UW   = NU * 4;
  localparam int NMAX = (ND > NT) ? ((ND > NU) ? ND : NU) : ((NT > NU) ? NT : NU);
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DPFX, S_DHEX, S_DLM1, S_TPFX, S_THEX, S_DLM2, S_UPFX, S_UHEX, S_TERM
  } state_t;

  // Handshakes: a beat moves on a channel only in a cycle where both valid
  // and ready are high at the rising edge; valid never drops before that.
  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_data;
  logic [TW-1:0]   r_dest;
  logic [UW-1:0]   r_user;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_s_tready;
  logic [7:0]      w_tdata;
  logic            w_accept;
  logic            w_mfire;
  logic [3:0]      w_nib_d;
  logic [3:0]      w_nib_t;
  logic [3:0]      w_nib_u;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_accept = (r_state == S_IDLE) && r_s_tready && s_axis_tvalid;
  assign w_mfire  = m_axis_tvalid && m_axis_tready;
  assign w_nib_d  = 4'(r_data >> {r_cnt, 2'b00});
  assign w_nib_t  = 4'(r_dest >> {r_cnt, 2'b00});
  assign w_nib_u  = 4'(r_user >> {r_cnt, 2'b00});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tdata     = 8'h00;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_DPFX;
      S_DPFX: begin
        w_tdata = DATA_PREFIX;
        if (w_mfire) begin w_state_nxt = S_DHEX; w_cnt_nxt = CW'(ND - 1); end
      end
      S_DHEX: begin
        w_tdata = hex_ascii(w_nib_d);
        if (w_mfire) begin
          if (r_cnt == '0) w_state_nxt = S_DLM1;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_DLM1: begin
        w_tdata = DELIMITER;
        if (w_mfire) w_state_nxt = S_TPFX;
      end
      S_TPFX: begin
        w_tdata = DEST_PREFIX;
        if (w_mfire) begin w_state_nxt = S_THEX; w_cnt_nxt = CW'(NT - 1); end
      end
      S_THEX: begin
        w_tdata = hex_ascii(w_nib_t);
        if (w_mfire) begin
          if (r_cnt == '0) w_state_nxt = S_DLM2;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_DLM2: begin
        w_tdata = DELIMITER;
        if (w_mfire) w_state_nxt = S_UPFX;
      end
      S_UPFX: begin
        w_tdata = USER_PREFIX;
        if (w_mfire) begin w_state_nxt = S_UHEX; w_cnt_nxt = CW'(NU - 1); end
      end
      S_UHEX: begin
        w_tdata = hex_ascii(w_nib_u);
        if (w_mfire) begin
          if (r_cnt == '0) w_state_nxt = S_TERM;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_TERM: begin
        w_tdata = TERMINATION;
        if (w_mfire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low through reset
  // and rises one cycle after release or after the terminator handshake.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_dest     <= '0;
      r_user     <= '0;
      r_s_tready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s_tready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_data <= DW'(s_axis_tdata);
        r_dest <= TW'(s_axis_tdest);
        r_user <= UW'(s_axis_tuser);
      end
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = (r_state != S_IDLE);
  assign m_axis_tlast  = (r_state == S_TERM);
  assign m_axis_tdata  = w_tdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_data_to_axis_string.sv
// Bench for axis_data_to_axis_string: default instance plus a wide/odd-width
// instance, each with an expected-byte queue checked at the output.
module tb_axis_data_to_axis_string;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // default instance
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [3:0] s_tuser;
  logic [3:0] s_tdest;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;
  logic [3:0] dbg1;

  // SBUS_WIDTH=2, DEST_WIDTH=5, USER_WIDTH=1 instance
  logic [15:0] s2_tdata;
  logic        s2_tvalid;
  logic        s2_tready;
  logic [0:0]  s2_tuser;
  logic [4:0]  s2_tdest;
  logic [7:0]  m2_tdata;
  logic        m2_tvalid;
  logic        m2_tlast;
  logic        m2_tready;
  logic [3:0]  dbg2;

  axis_data_to_axis_string u_dut (
    .aclk(clk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .o_dbg_state(dbg1)
  );

  axis_data_to_axis_string #(.SBUS_WIDTH(2), .DEST_WIDTH(5), .USER_WIDTH(1)) u_dut2 (
    .aclk(clk), .arstn(arstn),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .s_axis_tuser(s2_tuser), .s_axis_tdest(s2_tdest),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tlast(m2_tlast),
    .m_axis_tready(m2_tready), .o_dbg_state(dbg2)
  );

  // {tlast, byte}
  logic [8:0] exp_q[$];
  logic [8:0] exp_q2[$];
  int n_total = 0;
  int n_bad   = 0;
  int n_pop1  = 0;
  int n_pop2  = 0;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    string digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic push_line(input bit second, input logic [31:0] d, input int nd,
                           input logic [31:0] t, input int nt,
                           input logic [31:0] u, input int nu);
    logic [7:0] b[$];
    b.push_back(8'h23);
    for (int i = nd - 1; i >= 0; i--) b.push_back(hx(4'(d >> (i * 4))));
    b.push_back(8'h3B);
    b.push_back(8'h26);
    for (int i = nt - 1; i >= 0; i--) b.push_back(hx(4'(t >> (i * 4))));
    b.push_back(8'h3B);
    b.push_back(8'h2A);
    for (int i = nu - 1; i >= 0; i--) b.push_back(hx(4'(u >> (i * 4))));
    b.push_back(8'h0A);
    for (int k = 0; k < b.size(); k++) begin
      if (second) exp_q2.push_back({(k == b.size() - 1), b[k]});
      else        exp_q.push_back({(k == b.size() - 1), b[k]});
    end
  endtask

  // output ready driver: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random
  initial begin
    int pat_i;
    logic [3:0] pat;
    pat = 4'b1001;
    pat_i = 0;
    m_tready = 1'b1;
    m2_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_tready = pat[3 - (pat_i % 4)];
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b1;
      endcase
      pat_i++;
    end
  end

  // output monitor, default instance: pops on handshake, checks stall stability
  logic       stall_seen = 1'b0;
  logic [8:0] stall_byte;
  always @(negedge clk) begin
    if (arstn) begin
      if (stall_seen) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_byte", {m_tlast, m_tdata}, stall_byte);
      end
      stall_seen = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_byte_q1", exp_q.size(), 1);
        else begin
          check("byte_q1", {m_tlast, m_tdata}, exp_q.pop_front());
          n_pop1++;
        end
      end else if (m_tvalid) begin
        stall_seen = 1'b1;
        stall_byte = {m_tlast, m_tdata};
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (arstn && m2_tvalid && m2_tready) begin
      if (exp_q2.size() == 0) check("unexpected_byte_q2", exp_q2.size(), 1);
      else begin
        check("byte_q2", {m2_tlast, m2_tdata}, exp_q2.pop_front());
        n_pop2++;
      end
    end
  end

  // drives one beat on the default instance; returns the handshake cycle
  task automatic send(input logic [7:0] d, input logic [3:0] t, input logic [3:0] u, output int hs);
    s_tdata = d; s_tdest = t; s_tuser = u; s_tvalid = 1'b1;
    push_line(1'b0, 32'(d), 2, 32'(t), 1, 32'(u), 1);
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        hs = cyc;
        break;
      end
    end
    if (hs < 0) check("accept_timeout", s_tready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) @(posedge clk);
    check("drain_q1", exp_q.size(), 0);
    check("drain_q2", exp_q2.size(), 0);
    @(posedge clk);
    #1;
    check("idle_tvalid", m_tvalid, 0);
    check("idle_tvalid2", m2_tvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs1, hs2, base;
    s_tvalid = 1'b0; s_tdata = '0; s_tdest = '0; s_tuser = '0;
    s2_tvalid = 1'b0; s2_tdata = '0; s2_tdest = '0; s2_tuser = '0;

    // reset values and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_s2_tready", s2_tready, 0);
    @(negedge clk);
    arstn = 1'b1;
    #1;
    check("rel_s_tready_before_edge", s_tready, 0);
    @(posedge clk);
    #1;
    check("rel_s_tready", s_tready, 1);
    check("rel_m_tvalid", m_tvalid, 0);

    // basic conversion with first-byte latency
    send(8'hA5, 4'h3, 4'hC, hs1);
    s_tvalid = 1'b0;
    check("lat_m_tvalid", m_tvalid, 1);
    check("lat_m_tdata", m_tdata, 8'h23);
    check("lat_s_tready", s_tready, 0);
    drain();

    // backpressure 1-0-0-1
    rdy_mode = 1;
    send(8'h09, 4'h0, 4'hF, hs1);
    s_tvalid = 1'b0;
    drain();
    rdy_mode = 0;

    // back-to-back beats with tvalid held high
    send(8'h00, 4'h0, 4'h0, hs1);
    send(8'hFF, 4'hF, 4'hF, hs2);
    s_tvalid = 1'b0;
    check("b2b_spacing", hs2 - hs1, 11);
    drain();

    // random beats under random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), hs1);
      if (k % 2 == 1) s_tvalid = 1'b0;
    end
    s_tvalid = 1'b0;
    drain();
    rdy_mode = 0;

    // width configuration instance
    s2_tdata = 16'h1234; s2_tdest = 5'h11; s2_tuser = 1'b1; s2_tvalid = 1'b1;
    push_line(1'b1, 32'h1234, 4, 32'h11, 2, 32'h1, 1);
    hs1 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s2_tready) begin
        @(posedge clk);
        #1;
        hs1 = cyc;
        break;
      end
    end
    if (hs1 < 0) check("accept_timeout2", s2_tready, 1);
    s2_tvalid = 1'b0;
    drain();
    check("w2_line_len", n_pop2, 13);

    // mid-line reset after the 4th output byte
    base = n_pop1;
    send(8'h3C, 4'h1, 4'h7, hs1);
    s_tvalid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (n_pop1 >= base + 4) break;
    end
    check("mid_bytes_before_reset", n_pop1 - base, 4);
    arstn = 1'b0;
    #1;
    check("mid_m_tvalid", m_tvalid, 0);
    check("mid_m_tlast", m_tlast, 0);
    check("mid_m_tdata", m_tdata, 0);
    check("mid_s_tready", s_tready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mid_hold_tvalid", m_tvalid, 0);
    @(negedge clk);
    arstn = 1'b1;
    send(8'h5A, 4'h2, 4'h4, hs1);
    s_tvalid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
